// File: rtl/mem_arbiter.sv
// Two-requester arbiter onto one memory port, with in-order response routing.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 1.
module mem_arbiter #(
  parameter int XLEN            = 32,
  parameter int MASK_BITS       = XLEN / 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 p0_ready_o,
  input  logic                 p0_valid_i,
  input  logic [XLEN-1:0]      p0_addr_i,
  input  logic [XLEN-1:0]      p0_wdata_i,
  input  logic [MASK_BITS-1:0] p0_wmask_i,
  output logic [XLEN-1:0]      p0_rdata_o,
  output logic                 p0_rvalid_o,
  output logic                 p1_ready_o,
  input  logic                 p1_valid_i,
  input  logic [XLEN-1:0]      p1_addr_i,
  input  logic [XLEN-1:0]      p1_wdata_i,
  input  logic [MASK_BITS-1:0] p1_wmask_i,
  output logic [XLEN-1:0]      p1_rdata_o,
  output logic                 p1_rvalid_o,
  input  logic                 mem_ready_i,
  output logic                 mem_valid_o,
  output logic [XLEN-1:0]      mem_addr_o,
  output logic [XLEN-1:0]      mem_wdata_o,
  output logic [MASK_BITS-1:0] mem_wmask_o,
  input  logic [XLEN-1:0]      mem_rdata_i,
  input  logic                 mem_rvalid_i,
  output logic                 err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ids_q [MAX_OUTSTANDING];
  logic          err_q, err_d;

  logic any_valid, both_valid, pick1, gnt1, gnt_active, gnt_valid;
  logic can_issue, accept, pop, head_id;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign any_valid  = p0_valid_i | p1_valid_i;
  assign both_valid = p0_valid_i & p1_valid_i;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
  assign pick1  = both_valid ? ~last_q : p1_valid_i;
  assign last_d = accept ? gnt1 : last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  assign pick1 = p1_valid_i;
`endif

  always_comb begin
    gnt1       = pick1;
    gnt_active = any_valid;
    case (state_q)
      ST_GRANT0: begin gnt1 = 1'b0; gnt_active = 1'b1; end
      ST_GRANT1: begin gnt1 = 1'b1; gnt_active = 1'b1; end
      default:   ;
    endcase
  end

  assign gnt_valid = gnt1 ? p1_valid_i : p0_valid_i;
  // A full FIFO may still accept when a response frees a slot this same cycle.
  assign can_issue = (count_q < MAX_CNT) | (mem_rvalid_i & (count_q != '0));

  assign mem_valid_o = ~rst_i & gnt_active & gnt_valid & can_issue;
  assign mem_addr_o  = gnt1 ? p1_addr_i  : p0_addr_i;
  assign mem_wdata_o = gnt1 ? p1_wdata_i : p0_wdata_i;
  assign mem_wmask_o = gnt1 ? p1_wmask_i : p0_wmask_i;

  assign p0_ready_o = ~rst_i & gnt_active & ~gnt1 & mem_ready_i & can_issue;
  assign p1_ready_o = ~rst_i & gnt_active &  gnt1 & mem_ready_i & can_issue;

  assign accept  = mem_valid_o & mem_ready_i;
  assign pop     = ~rst_i & mem_rvalid_i & (count_q != '0);
  assign head_id = ids_q[rd_ptr_q];

  assign p0_rvalid_o = pop & ~head_id;
  assign p1_rvalid_o = pop &  head_id;
  assign p0_rdata_o  = mem_rdata_i;
  assign p1_rdata_o  = mem_rdata_i;
  assign err_o       = err_q & ~rst_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (mem_valid_o && !mem_ready_i) state_d = gnt1 ? ST_GRANT1 : ST_GRANT0;
      ST_GRANT0,
      ST_GRANT1: if (accept) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
    wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop    ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    err_d    = err_q | (mem_rvalid_i & (count_q == '0));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) ids_q[wr_ptr_q] <= gnt1;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32: address and data width.
REQ-002 Parameter MASK_BITS, default XLEN/8: write-mask width (one bit per byte).
REQ-003 Parameter MAX_OUTSTANDING, default 2, range 1..8: capacity of the response-routing FIFO.
REQ-004 Port clk_i, in, 1: the single clock; all state updates on the rising edge.
REQ-005 Port rst_i, in, 1: reset, synchronous and active-high.
REQ-006 Ports p0_ready_o (out, 1), p0_valid_i (in, 1), p0_addr_i (in, XLEN), p0_wdata_i (in, XLEN), p0_wmask_i (in, MASK_BITS), p0_rdata_o (out, XLEN), p0_rvalid_o (out, 1): requester 0, the instruction fetch port.
REQ-007 Ports p1_ready_o, p1_valid_i, p1_addr_i, p1_wdata_i, p1_wmask_i, p1_rdata_o, p1_rvalid_o, same widths as REQ-006: requester 1, the LSU data port.
REQ-008 Ports mem_ready_i (in, 1), mem_valid_o (out, 1), mem_addr_o (out, XLEN), mem_wdata_o (out, XLEN), mem_wmask_o (out, MASK_BITS), mem_rdata_i (in, XLEN), mem_rvalid_i (in, 1): the shared downstream memory.
REQ-009 Port err_o, out, 1: sticky flag, set when a response arrives unexpected.

Function
REQ-010 Handshake: a request transfers when valid and ready are both high in the same cycle; the downstream memory returns exactly one rvalid per accepted request (reads and writes), in order, at least 1 cycle after acceptance.
REQ-011 Requesters hold valid, addr, wdata and wmask stable until their request is accepted.
REQ-012 States:
- IDLE: no grant held.
- GRANT0: port 0 granted, request not yet accepted.
- GRANT1: port 1 granted, request not yet accepted.
REQ-013 In IDLE with any valid and can_issue: choose a winner per REQ-021/022, drive its request to mem combinationally in the same cycle, and enter GRANTx if mem_ready_i is low.
REQ-014 In GRANTx: keep the grant on port x, ignoring the other port, until mem_valid_o && mem_ready_i; then return to IDLE. Zero-cycle arbitration resumes the next cycle.
REQ-015 mem_valid_o = granted port valid && can_issue. mem_addr_o, mem_wdata_o and mem_wmask_o are muxed from the granted port. Only the granted port sees px_ready_o = mem_ready_i && can_issue; the other port's ready is 0.
REQ-016 can_issue = (count < MAX_OUTSTANDING) || (mem_rvalid_i && count != 0). Acceptance while full is allowed only when a response pops in the same cycle.
REQ-017 Each accepted request pushes its port ID into the routing FIFO. Each mem_rvalid_i with count != 0 pops the head and asserts p<head>_rvalid_o in that same cycle. mem_rdata_i is broadcast to both rdata outputs.
REQ-018 Push and pop in the same cycle leave count unchanged. FIFO pointers wrap modulo MAX_OUTSTANDING.
REQ-019 mem_rvalid_i with count == 0: no px_rvalid_o asserted, and err_o is set and held until reset.
REQ-020 Granted port dropping valid before acceptance is illegal: behaviour is undefined and is not checked.

Configuration
REQ-021 With MEM_ARB_RR_EN undefined: fixed priority, port 1 (data) wins when both are valid in IDLE.
REQ-022 With MEM_ARB_RR_EN defined: round-robin. A last-winner register, reset to 1, is updated on each acceptance. When both are valid, the port that is not the last winner wins.

Reset
REQ-023 While rst_i is high at a clock edge: state IDLE, count 0, pointers 0, err_o 0, last-winner 1.
REQ-024 During and after reset, all outputs are 0: p0/p1_ready_o, p0/p1_rvalid_o, mem_valid_o and err_o.
REQ-025 Reset mid-transaction discards all outstanding IDs. Responses arriving after reset set err_o per REQ-019.

Verification
REQ-026 Both ports valid in IDLE, mem_ready_i=1, fixed priority -> cycle 0 accepts p1 (mem_addr_o=p1_addr), cycle 1 accepts p0. With MEM_ARB_RR_EN, alternate p0, p1, p0, ... under continuous requests.
REQ-027 p0 valid with mem_ready_i=0 for 3 cycles, p1 valid from cycle 1 -> mem_addr_o stays p0_addr and p1_ready_o=0 until p0 is accepted at cycle 3.
REQ-028 MAX_OUTSTANDING=2, accept p0 then p1, no responses yet -> can_issue=0 and both readies low. Then mem_rvalid_i=1 with rdata=0xDEADBEEF -> p0_rvalid_o=1 with that data, and a third request is accepted in the same cycle.
REQ-029 Responses for an ID sequence 1,0,1 -> p1_rvalid_o, p0_rvalid_o, p1_rvalid_o in order. Count returns to 0.
REQ-030 mem_rvalid_i=1 with count=0 -> no rvalid on either port, err_o=1 and held. rst_i pulse -> err_o=0 and all outputs 0.
